// File: rtl/lab3_pkg.sv
// Shared constants for the lab3 button front-end and control FSM.
package lab3_pkg;

    localparam int unsigned N_BUTTONS       = 4;
    localparam int unsigned CLK_HZ          = 100_000_000;
    localparam int unsigned DEBOUNCE_MS     = 10;
    localparam int unsigned DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned BTN_IDX_W       = $clog2(N_BUTTONS);

    typedef logic [BTN_IDX_W-1:0] btn_idx_t;

    // Button indices as seen by the downstream control FSM
    localparam btn_idx_t CMD_INIT  = btn_idx_t'(1);
    localparam btn_idx_t CMD_ALPHA = btn_idx_t'(2);
    localparam btn_idx_t CMD_BRAVO = btn_idx_t'(3);

    // Width of a counter that must hold values 0..cycles
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button channel: 2-flop synchronizer, stability counter, debounced
// level and single-cycle press/release pulses.
module debounce_bit
    import lab3_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = lab3_pkg::DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic button_n,
    output logic level,
    output logic press,
    output logic rel,
    output logic press_next
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             sync_hi;

    assign sync_hi = ~sync2_q;

    // Two-stage synchronizer for the asynchronous raw input
    always_comb begin
        sync1_d = button_n;
        sync2_d = sync1_q;
    end

    // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        cnt_d   = '0;
        if (sync_hi != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                press_d = ~level_q;
                rel_d   = level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; synchronizer resets to the released state
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level      = level_q;
    assign press      = press_q;
    assign rel        = rel_q;
    // Next-cycle press lets the parent register its command on the same edge
    assign press_next = press_d;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front-end: per-button debounce plus a priority-encoded
// command strobe so the control FSM sees one event per press.
module button_conditioner
    import lab3_pkg::*;
#(
    parameter int unsigned N_BUTTONS       = lab3_pkg::N_BUTTONS,
    parameter int unsigned DEBOUNCE_CYCLES = lab3_pkg::DEBOUNCE_CYCLES
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [N_BUTTONS-1:0]                                 button,
    output logic [N_BUTTONS-1:0]                                 btn_level,
    output logic [N_BUTTONS-1:0]                                 btn_press,
    output logic [N_BUTTONS-1:0]                                 btn_release,
    output logic                                                 cmd_valid,
    output logic [((N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1)-1:0] cmd_idx
);

    localparam int unsigned IDX_W = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;

    logic [N_BUTTONS-1:0] press_next;
    logic                 cmd_valid_q, cmd_valid_d;
    logic [IDX_W-1:0]     cmd_idx_q, cmd_idx_d;

    genvar g;
    generate
        for (g = 0; g < N_BUTTONS; g++) begin : g_btn
            debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk       (clk),
                .rst       (rst),
                .button_n  (button[g]),
                .level     (btn_level[g]),
                .press     (btn_press[g]),
                .rel       (btn_release[g]),
                .press_next(press_next[g])
            );
        end
    endgenerate

    // Lowest-index accepted press wins the command slot
    always_comb begin
        logic found;
        found       = 1'b0;
        cmd_idx_d   = '0;
        cmd_valid_d = |press_next;
        for (int unsigned i = 0; i < N_BUTTONS; i++) begin
            if (press_next[i] && !found) begin
                cmd_idx_d = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end

    // Command registers, aligned with the btn_press pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_q <= 1'b0;
            cmd_idx_q   <= '0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_idx_q   <= cmd_idx_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_idx   = cmd_idx_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a window-based reference model.
module tb_button_conditioner;

    localparam int unsigned NB = 4;
    localparam int unsigned D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] button = 4'hF;
    logic [NB-1:0] btn_level, btn_press, btn_release;
    logic          cmd_valid;
    logic [1:0]    cmd_idx;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .N_BUTTONS      (NB),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .cmd_valid  (cmd_valid),
        .cmd_idx    (cmd_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a button's level flips when the last D synchronized
    // samples all disagree with it; samples lag the pin by two edges.
    bit            mdl_on = 1'b0;
    bit [NB-1:0]   m_level, m_press, m_rel;
    bit            m_cv;
    bit [1:0]      m_idx;
    bit [NB-1:0]   r1, r2;
    bit            win [NB][$];

    always @(posedge clk) begin
        if (rst) begin
            mdl_on  = 1'b1;
            m_level = '0;
            m_press = '0;
            m_rel   = '0;
            m_cv    = 1'b0;
            m_idx   = '0;
            r1      = '0;
            r2      = '0;
            for (int i = 0; i < NB; i++) win[i].delete();
        end else begin
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < NB; i++) begin
                int unsigned diff;
                win[i].push_back(r2[i]);
                if (win[i].size() > D) void'(win[i].pop_front());
                diff = 0;
                foreach (win[i][k]) if (win[i][k] != m_level[i]) diff++;
                if (win[i].size() == D && diff == D) begin
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) m_press[i] = 1'b1;
                    else            m_rel[i]   = 1'b1;
                end
                r2[i] = r1[i];
                r1[i] = ~button[i];
            end
            m_cv  = |m_press;
            m_idx = '0;
            for (int i = NB - 1; i >= 0; i--) if (m_press[i]) m_idx = 2'(i);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (mdl_on) begin
            chk("level", btn_level, m_level);
            chk("press", btn_press, m_press);
            chk("release", btn_release, m_rel);
            chk("cmd_valid", cmd_valid, m_cv);
            if (m_cv) chk("cmd_idx", cmd_idx, m_idx);
        end
    end

    initial begin
        int cnt, bad;

        // Reset idle
        rst    = 1'b1;
        button = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_level", btn_level, 0);
        chk("rst_press", btn_press, 0);
        chk("rst_release", btn_release, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_idx", cmd_idx, 0);
        cnt = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (btn_level != 0 || btn_press != 0 || btn_release != 0 || cmd_valid) cnt++;
        end
        chk("idle_activity", cnt, 0);

        // Clean press and release of button 2
        @(negedge clk); button = 4'b1011;
        cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (btn_level != 0 || btn_press != 0 || cmd_valid) cnt++;
        end
        chk("press_not_early", cnt, 0);
        @(posedge clk); #1;
        chk("press_level", btn_level, 4'b0100);
        chk("press_pulse", btn_press, 4'b0100);
        chk("press_cmd_valid", cmd_valid, 1);
        chk("press_cmd_idx", cmd_idx, 2);
        @(posedge clk); #1;
        chk("press_one_cycle", btn_press, 0);
        chk("cmd_one_cycle", cmd_valid, 0);
        repeat (13) @(posedge clk);
        @(negedge clk); button = 4'hF;
        cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (btn_release != 0 || btn_level != 4'b0100) cnt++;
        end
        chk("release_not_early", cnt, 0);
        @(posedge clk); #1;
        chk("release_pulse", btn_release, 4'b0100);
        chk("release_level", btn_level, 0);
        chk("release_no_cmd", cmd_valid, 0);
        repeat (10) @(posedge clk);

        // Bounce on button 1, then settle pressed
        cnt = 0;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk); button = (s % 2 == 1) ? 4'hF : 4'b1101;
            repeat (2) begin
                @(posedge clk); #1;
                if (btn_press != 0 || btn_level != 0) cnt++;
            end
        end
        @(negedge clk); button = 4'b1101;
        repeat (5) begin
            @(posedge clk); #1;
            if (btn_press != 0) cnt++;
        end
        chk("bounce_quiet", cnt, 0);
        @(posedge clk); #1;
        chk("bounce_press", btn_press, 4'b0010);
        chk("bounce_cmd_idx", cmd_idx, 1);
        repeat (3) @(posedge clk);
        @(negedge clk); button = 4'hF;
        repeat (12) @(posedge clk);

        // Simultaneous press of buttons 2 and 3
        @(negedge clk); button = 4'b0011;
        repeat (5) @(posedge clk);
        #1;
        @(posedge clk); #1;
        chk("simul_press", btn_press, 4'b1100);
        chk("simul_cmd_valid", cmd_valid, 1);
        chk("simul_cmd_idx", cmd_idx, 2);
        cnt = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (cmd_valid) cnt++;
        end
        chk("simul_single_cmd", cnt, 0);
        @(negedge clk); button = 4'hF;
        repeat (12) @(posedge clk);

        // Reset in the middle of debouncing button 3
        @(negedge clk); button = 4'b0111;
        cnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (btn_press != 0) cnt++;
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_level", btn_level, 0);
        @(negedge clk); rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (btn_press != 0) cnt++;
        end
        chk("midrst_no_early_press", cnt, 0);
        @(posedge clk); #1;
        chk("midrst_press", btn_press, 4'b1000);
        chk("midrst_cmd_idx", cmd_idx, 3);
        repeat (3) @(posedge clk);
        @(negedge clk); button = 4'hF;
        repeat (12) @(posedge clk);

        // Long hold of button 1: one press, no auto-repeat
        @(negedge clk); button = 4'b1101;
        cnt = 0;
        bad = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (btn_press[1]) cnt++;
            if (cmd_valid && cmd_idx != 2'd1) bad++;
            if (k >= 6 && !btn_level[1]) bad++;
        end
        chk("hold_press_count", cnt, 1);
        chk("hold_level_and_idx", bad, 0);
        @(negedge clk); button = 4'hF;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_level_before_release", btn_level, 4'b0010);
        @(posedge clk); #1;
        chk("hold_release", btn_release, 4'b0010);
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage between the board push-buttons and the lab3 control state machine. It synchronizes the four active-low `button` inputs into the `clk` domain, debounces each one independently, and emits active-high debounced levels plus single-cycle press and release pulses. It also provides a priority-encoded command strobe, so the downstream FSM sees exactly one event per physical press.

## Interface
- `N_BUTTONS`, 4: number of button inputs.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable samples required to accept a change. The default is 10 ms at 100 MHz. Legal range is 1 or greater.
- `clk` input, 1 bit: system clock, derived from `sys_clkp`/`sys_clkn` (100 MHz).
- `rst` input, 1 bit: reset, synchronous and active-high.
- `button` input, N_BUTTONS bits: raw board buttons, active-low (0 = pressed) and asynchronous.
- `btn_level` output, N_BUTTONS bits: debounced state, active-high (1 = pressed).
- `btn_press` output, N_BUTTONS bits: one-cycle pulse when `btn_level[i]` goes 0→1.
- `btn_release` output, N_BUTTONS bits: one-cycle pulse when `btn_level[i]` goes 1→0.
- `cmd_valid` output, 1 bit: one-cycle pulse whenever any `btn_press` bit is 1.
- `cmd_idx` output, $clog2(N_BUTTONS) bits: index of the lowest-numbered bit set in `btn_press`. Valid only while `cmd_valid` is 1.

## Operation
- **Synchronizer.** Each bit passes through a 2-flop synchronizer, then is inverted to active-high `sync[i]`.
- **Per-button debounce.** Each button has its own counter `cnt[i]`, width $clog2(DEBOUNCE_CYCLES+1).
  - If `sync[i]` equals `btn_level[i]`: `cnt[i]` is set to 0.
  - Otherwise `cnt[i]` increments. When `cnt[i]` reaches DEBOUNCE_CYCLES−1 while still differing, the next edge does all of the following: toggles `btn_level[i]`, clears `cnt[i]`, and raises `btn_press[i]` or `btn_release[i]` for that one cycle.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes `btn_level`. The counter restarts from 0 on every bounce.
- **Command encoding.**
  - `cmd_valid` and `cmd_idx` are registered on the same edge as `btn_press`.
  - If several buttons are accepted on the same edge, all their `btn_press` bits pulse, but `cmd_idx` reports the lowest index only. The higher-index presses produce no separate command.
- A held button produces no further pulses; there is no auto-repeat.
- Buttons never interact except through `cmd_idx` priority.

## Timing
- **Reset values.** Every output is 0: `btn_level`, `btn_press`, `btn_release`, `cmd_valid`, `cmd_idx`.
  - Synchronizer flops reset to 1 (released) and all counters reset to 0.
  - Coming out of reset with buttons released therefore produces no pulses.
- **Latency.** A clean change on `button[i]` sampled at edge k appears on `btn_level[i]`, the press/release pulse and `cmd_valid` at edge k+1+DEBOUNCE_CYCLES: 2 synchronizer stages, then DEBOUNCE_CYCLES differing samples.
- **Pulse width.** `btn_press`, `btn_release` and `cmd_valid` are high for exactly 1 cycle.
- **Reset mid-debounce.** Asserting `rst` clears the counter in progress and all outputs on that edge. A button still held after reset is accepted as a fresh press DEBOUNCE_CYCLES+2 cycles after `rst` deasserts.
- **Counter wrap.** The counter never wraps; it is cleared on acceptance or on agreement.
- **Minimum configuration.** DEBOUNCE_CYCLES=1 degenerates to synchronizer plus edge detect, with latency 2 cycles.

## Structure
- **Package `lab3_pkg`:**
  - `N_BUTTONS` = 4.
  - `CLK_HZ` = 100_000_000.
  - `DEBOUNCE_MS` constant and the derived default `DEBOUNCE_CYCLES`.
  - `BTN_IDX_W` = $clog2(N_BUTTONS).
  - Named indices for the FSM commands: 1 = init, 2 = alpha, 3 = bravo.
- **Sub-module `debounce_bit`.** Contains one synchronizer, counter and level flop, plus press/release pulse generation. The top instantiates it N_BUTTONS times with a generate loop and adds the priority encoder and the `cmd_*` registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and a 10 ns clock.
- **Reset idle.** `rst`=1 for 3 cycles, `button`=4'b1111 throughout → all outputs stay 0 for 50 cycles after release; no pulse.
- **Clean press and release.**
  - `button`=4'b1011 held 20 cycles → `btn_level`=4'b0100 exactly 6 edges after the change. `btn_press`=4'b0100 for one cycle, with `cmd_valid`=1 and `cmd_idx`=2 in that same cycle.
  - Return to 4'b1111 → `btn_release`=4'b0100 for one cycle, 6 edges later; no `cmd_valid`.
- **Bounce rejection.** `button[1]` toggles 0/1 every 2 cycles for 16 cycles, then stays 0 → exactly one `btn_press[1]`, 6 edges after the final settle; no pulses during the bounce.
- **Simultaneous press.** `button`=4'b0011 → `btn_press`=4'b1100 for one cycle, `cmd_valid`=1, `cmd_idx`=2; no second `cmd_valid`.
- **Reset mid-debounce.** `button`=4'b0111, then `rst` pulses 1 cycle after 3 cycles → no press before reset. After reset, `btn_press[3]` appears 6 edges after `rst` drops.
- **Long hold.** `button`=4'b1101 held 100 cycles → exactly one `btn_press[1]` and `cmd_idx`=1; `btn_level[1]` stays 1 until release.
